// File: rtl/pc_sequencer.sv
// Program-address sequencer with call/return stack; `PC_SEQ_SKIP_EN adds a skip input (enable+skip advances by 2).
// One-edge latency on value/depth/error flags, flags combinational from registers; no backpressure, one command per edge.
module pc_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4,
  parameter int WRAP        = 0,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [ADDR_W-1:0]  load_data,
  input  logic               call,
  input  logic               ret,
  input  logic               err_clear,
`ifdef PC_SEQ_SKIP_EN
  input  logic               skip,
`endif
  output logic [ADDR_W-1:0]  value,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               at_max,
  output logic               err_overflow,
  output logic               err_underflow
);

  logic [ADDR_W-1:0]  stack [STACK_DEPTH];
  logic [ADDR_W-1:0]  top;
  logic [ADDR_W-1:0]  ret_addr;
  logic [ADDR_W-1:0]  inc_value;
  logic [ADDR_W:0]    sum;
  logic [1:0]         step;
  logic [ADDR_W-1:0]  value_nxt;
  logic [DEPTH_W-1:0] depth_nxt;
  logic               push;
  logic               ovf_set;
  logic               unf_set;

  assign stack_full  = (depth == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (depth == '0);
  assign at_max      = &value;
  assign ret_addr    = value + 1'b1;

`ifdef PC_SEQ_SKIP_EN
  assign step = skip ? 2'd2 : 2'd1;
`else
  assign step = 2'd1;
`endif

  // The carry out of the widened sum marks a step past all-ones.
  always_comb begin
    sum = {1'b0, value} + {{(ADDR_W-1){1'b0}}, step};
    if (WRAP != 0) begin
      inc_value = sum[ADDR_W-1:0];
    end else begin
      inc_value = sum[ADDR_W] ? '1 : sum[ADDR_W-1:0];
    end
  end

  always_comb begin
    top = stack[0];
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth == DEPTH_W'(i + 1)) top = stack[i];
    end
  end

  always_comb begin
    value_nxt = value;
    depth_nxt = depth;
    push      = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (load) begin
      value_nxt = load_data;
    end else if (call) begin
      if (!stack_full) begin
        push      = 1'b1;
        depth_nxt = depth + 1'b1;
        value_nxt = load_data;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (ret) begin
      if (!stack_empty) begin
        value_nxt = top;
        depth_nxt = depth - 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end else if (enable) begin
      value_nxt = inc_value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value         <= '0;
      depth         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      value         <= value_nxt;
      depth         <= depth_nxt;
      // A new error in the same cycle as err_clear keeps the flag set.
      err_overflow  <= ovf_set | (err_overflow & ~err_clear);
      err_underflow <= unf_set | (err_underflow & ~err_clear);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (depth == DEPTH_W'(i)) stack[i] <= ret_addr;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: a saturating and a wrapping instance share one directed stimulus stream.
module tb_pc_sequencer;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] RST  = 7'b1000000;
  localparam logic [6:0] LD   = 7'b0100000;
  localparam logic [6:0] CL   = 7'b0010000;
  localparam logic [6:0] RT   = 7'b0001000;
  localparam logic [6:0] EN   = 7'b0000100;
  localparam logic [6:0] SK   = 7'b0000010;
  localparam logic [6:0] EC   = 7'b0000001;

  typedef struct packed {
    logic [11:0] v_sat;
    logic [11:0] v_wrap;
    logic [2:0]  dp;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0, err_clear = 1'b0, skip = 1'b0;
  logic [11:0] load_data = '0;

  logic [11:0] value_s, value_w;
  logic [2:0]  depth_s, depth_w;
  logic        full_s, full_w, empty_s, empty_w, max_s, max_w;
  logic        ovf_s, ovf_w, unf_s, unf_w;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clock = ~clock;

  pc_sequencer #(.ADDR_W(12), .STACK_DEPTH(4), .WRAP(0)) u_sat (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .load_data(load_data),
    .call(call), .ret(ret), .err_clear(err_clear),
`ifdef PC_SEQ_SKIP_EN
    .skip(skip),
`endif
    .value(value_s), .depth(depth_s), .stack_full(full_s), .stack_empty(empty_s),
    .at_max(max_s), .err_overflow(ovf_s), .err_underflow(unf_s)
  );

  pc_sequencer #(.ADDR_W(12), .STACK_DEPTH(4), .WRAP(1)) u_wrap (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .load_data(load_data),
    .call(call), .ret(ret), .err_clear(err_clear),
`ifdef PC_SEQ_SKIP_EN
    .skip(skip),
`endif
    .value(value_w), .depth(depth_w), .stack_full(full_w), .stack_empty(empty_w),
    .at_max(max_w), .err_overflow(ovf_w), .err_underflow(unf_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: every output update is compared against the oldest queued expectation.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("value_sat",   32'(value_s), 32'(e.v_sat));
      chk("value_wrap",  32'(value_w), 32'(e.v_wrap));
      chk("at_max_sat",  32'(max_s),   32'(e.v_sat == 12'hFFF));
      chk("at_max_wrap", 32'(max_w),   32'(e.v_wrap == 12'hFFF));
      chk("depth",       32'(depth_s), 32'(e.dp));
      chk("depth_wrap",  32'(depth_w), 32'(e.dp));
      chk("stack_full",  32'(full_s),  32'(e.dp == 3'd4));
      chk("stack_empty", 32'(empty_s), 32'(e.dp == 3'd0));
      chk("err_ovf",     32'(ovf_s),   32'(e.ovf));
      chk("err_unf",     32'(unf_s),   32'(e.unf));
    end
  end

  task automatic cyc(input logic [6:0] cmd, input logic [11:0] d, input logic [11:0] es,
                     input logic [11:0] ew, input logic [2:0] edp, input logic eovf, input logic eunf);
    exp_t e;
    @(negedge clock);
    {reset, load, call, ret, enable, skip, err_clear} = cmd;
    load_data = d;
    e.v_sat = es; e.v_wrap = ew; e.dp = edp; e.ovf = eovf; e.unf = eunf;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset, count, reset mid-count
    cyc(RST, 12'h000, 12'h000, 12'h000, 3'd0, 0, 0);
    for (int i = 1; i <= 6; i++) cyc(EN, 12'h000, 12'(i), 12'(i), 3'd0, 0, 0);
    cyc(RST | EN | LD, 12'h555, 12'h000, 12'h000, 3'd0, 0, 0);
    // 2. saturate vs wrap
    cyc(LD, 12'hFFE, 12'hFFE, 12'hFFE, 3'd0, 0, 0);
    cyc(EN, 12'h000, 12'hFFF, 12'hFFF, 3'd0, 0, 0);
    cyc(EN, 12'h000, 12'hFFF, 12'h000, 3'd0, 0, 0);
    cyc(EN, 12'h000, 12'hFFF, 12'h001, 3'd0, 0, 0);
    // 3. nested call/return
    cyc(LD, 12'h010, 12'h010, 12'h010, 3'd0, 0, 0);
    cyc(CL, 12'h100, 12'h100, 12'h100, 3'd1, 0, 0);
    cyc(EN, 12'h000, 12'h101, 12'h101, 3'd1, 0, 0);
    cyc(EN, 12'h000, 12'h102, 12'h102, 3'd1, 0, 0);
    cyc(CL, 12'h200, 12'h200, 12'h200, 3'd2, 0, 0);
    cyc(NONE, 12'h000, 12'h200, 12'h200, 3'd2, 0, 0);
    cyc(RT, 12'h000, 12'h103, 12'h103, 3'd1, 0, 0);
    cyc(RT, 12'h000, 12'h011, 12'h011, 3'd0, 0, 0);
    // 4. fill, overflow, clear (set beats clear), drain
    cyc(CL, 12'h001, 12'h001, 12'h001, 3'd1, 0, 0);
    cyc(CL, 12'h002, 12'h002, 12'h002, 3'd2, 0, 0);
    cyc(CL, 12'h003, 12'h003, 12'h003, 3'd3, 0, 0);
    cyc(CL, 12'h004, 12'h004, 12'h004, 3'd4, 0, 0);
    cyc(CL, 12'h300, 12'h004, 12'h004, 3'd4, 1, 0);
    cyc(EC, 12'h000, 12'h004, 12'h004, 3'd4, 0, 0);
    cyc(CL | EC, 12'h300, 12'h004, 12'h004, 3'd4, 1, 0);
    cyc(EC, 12'h000, 12'h004, 12'h004, 3'd4, 0, 0);
    cyc(RT, 12'h000, 12'h004, 12'h004, 3'd3, 0, 0);
    cyc(RT, 12'h000, 12'h003, 12'h003, 3'd2, 0, 0);
    cyc(RT, 12'h000, 12'h002, 12'h002, 3'd1, 0, 0);
    cyc(RT, 12'h000, 12'h012, 12'h012, 3'd0, 0, 0);
    // 5. underflow and priority
    cyc(RT, 12'h000, 12'h012, 12'h012, 3'd0, 0, 1);
    cyc(LD | CL | EN, 12'h0AA, 12'h0AA, 12'h0AA, 3'd0, 0, 1);
    cyc(CL | RT, 12'h050, 12'h050, 12'h050, 3'd1, 0, 1);
    cyc(EC, 12'h000, 12'h050, 12'h050, 3'd1, 0, 0);
    cyc(RT | EN, 12'h000, 12'h0AB, 12'h0AB, 3'd0, 0, 0);
    cyc(RT | EC, 12'h000, 12'h0AB, 12'h0AB, 3'd0, 0, 1);
    cyc(EC, 12'h000, 12'h0AB, 12'h0AB, 3'd0, 0, 0);
    // return address wraps modulo 2^12 even when saturating
    cyc(LD, 12'hFFF, 12'hFFF, 12'hFFF, 3'd0, 0, 0);
    cyc(CL, 12'h010, 12'h010, 12'h010, 3'd1, 0, 0);
    cyc(RT, 12'h000, 12'h000, 12'h000, 3'd0, 0, 0);
`ifdef PC_SEQ_SKIP_EN
    // 6. skip
    cyc(LD, 12'h020, 12'h020, 12'h020, 3'd0, 0, 0);
    cyc(EN | SK, 12'h000, 12'h022, 12'h022, 3'd0, 0, 0);
    cyc(SK, 12'h000, 12'h022, 12'h022, 3'd0, 0, 0);
    cyc(LD, 12'hFFE, 12'hFFE, 12'hFFE, 3'd0, 0, 0);
    cyc(EN | SK, 12'h000, 12'hFFF, 12'h000, 3'd0, 0, 0);
    cyc(LD, 12'hFFF, 12'hFFF, 12'hFFF, 3'd0, 0, 0);
    cyc(EN | SK, 12'h000, 12'hFFF, 12'h001, 3'd0, 0, 0);
    cyc(LD | EN | SK, 12'h100, 12'h100, 12'h100, 3'd0, 0, 0);
`endif
    @(negedge clock);
    {reset, load, call, ret, enable, skip, err_clear} = NONE;
    repeat (3) @(negedge clock);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
